// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first REPS times with GAP idle cycles between frames.
// Define TX_PARITY_EN to append an even-parity bit to every frame.
module seq_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

`ifdef TX_PARITY_EN
  localparam int F = PAT_W + 1;
`else
  localparam int F = PAT_W;
`endif
  localparam int PW = $clog2(F);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(F - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             out_d, valid_d, busy_d, done_d;

  // Bit p of a frame, counting from the MSB; the slot after the LSB carries parity.
  function automatic logic frame_bit(input logic [PAT_W-1:0] pat, input logic [PW-1:0] p);
    logic [PAT_W-1:0] sh;
`ifdef TX_PARITY_EN
    if (p == PW'(PAT_W)) return ^pat;
`endif
    sh = pat << p;
    return sh[PAT_W-1];
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d = pattern;
          if (reps != '0) begin
            state_d = S_SHIFT;
            pos_d   = '0;
            rem_d   = reps;
            out_d   = pattern[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pos_q != POS_LAST) begin
          pos_d   = pos_q + 1'b1;
          out_d   = frame_bit(pat_q, pos_q + 1'b1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          // rem_q counts frames still owed including this one, so it never wraps
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = '0;
            busy_d  = 1'b1;
          end else begin
            pos_d   = '0;
            out_d   = pat_q[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SHIFT;
          pos_d   = '0;
          out_d   = pat_q[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: a frame-list reference model plus literal sequences.
// Define TX_PARITY_EN to exercise the parity build (GAP=0).
module tb_seq_tx;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
`ifdef TX_PARITY_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] reps = '0;
  logic             abort = 1'b0;
  logic             out, valid, busy, done;

  int checks = 0;
  int errors = 0;

  // Expected {out,valid,busy,done} for the current cycle and for the cycles to come
  logic [3:0] cur = 4'h0;
  logic [3:0] exp_q[$];

  seq_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .abort(abort), .out(out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic build_run(input logic [PAT_W-1:0] pat, input int n);
    logic [PAT_W-1:0] t;
    for (int f = 0; f < n; f++) begin
      t = pat;
      for (int p = 0; p < PAT_W; p++) begin
        exp_q.push_back({t[PAT_W-1], 3'b110});
        t = t << 1;
      end
`ifdef TX_PARITY_EN
      exp_q.push_back({^pat, 3'b110});
`endif
      if (f < n - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur = 4'h0;
    end else if (abort) begin
      exp_q.delete();
      cur = 4'h0;
    end else if (exp_q.size() == 0 && !cur[0]) begin
      if (start) begin
        build_run(pattern, int'(reps));
        cur = exp_q.pop_front();
      end else begin
        cur = 4'h0;
      end
    end else begin
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if ({out, valid, busy, done} !== cur) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t got=%b want=%b", $time, {out, valid, busy, done}, cur);
    end
  end

  task automatic check_output(input string name, input logic [3:0] want);
    checks++;
    if ({out, valid, busy, done} !== want) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%b want=%b", name, $time, {out, valid, busy, done}, want);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [PAT_W-1:0] p,
                                input logic [CNT_W-1:0] r, input logic a);
    start   = s;
    pattern = p;
    reps    = r;
    abort   = a;
  endtask

  // Checks len nibbles of seq (MSB first), one per cycle; start drops after check number drop_at
  task automatic check_seq(input string name, input logic [47:0] seq, input int len, input int drop_at);
    logic [47:0] s;
    s = seq;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check_output(name, s[47:44]);
      s = s << 4;
      if (i == drop_at) start = 1'b0;
    end
  endtask

  initial begin
    $display("[TB] seq_tx bench start");
    #1 check_output("reset_state", 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifndef TX_PARITY_EN
    apply_stimulus(1'b1, 4'b1101, 4'd1, 1'b0);
    check_seq("single_1101", 48'hEE6E10_000000, 6, 0);

    apply_stimulus(1'b1, 4'b1011, 4'd2, 1'b0);
    check_seq("two_frames_1011", 48'hE6EE2E6EE100, 11, 0);
`else
    apply_stimulus(1'b1, 4'b1101, 4'd2, 1'b0);
    check_seq("parity_1101", 48'hEE6EEEE6EE10, 12, 0);
`endif

    apply_stimulus(1'b1, 4'b1111, 4'd0, 1'b0);
    check_seq("reps_zero", 48'h100000_000000, 3, 1);

    apply_stimulus(1'b1, 4'b1010, 4'd2, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b0, 4'b0000, 4'd0, 1'b0);
    check_output("abort_start_idle", 4'h0);
    @(negedge clk);
    check_output("abort_start_idle2", 4'h0);

`ifndef TX_PARITY_EN
    apply_stimulus(1'b1, 4'b1100, 4'd3, 1'b0);
    check_seq("abort_pre", 48'hEE662EE00000, 7, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_flush", 4'h0);
    @(negedge clk);
    check_output("abort_no_done", 4'h0);
    apply_stimulus(1'b1, 4'b0110, 4'd1, 1'b0);
    check_seq("after_abort", 48'h6EE610_000000, 6, 0);
`endif

    apply_stimulus(1'b1, 4'b1111, 4'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_output("async_reset", 4'h0);
    @(negedge clk);
    rst = 1'b1;
`ifndef TX_PARITY_EN
    apply_stimulus(1'b1, 4'b1001, 4'd1, 1'b0);
    check_seq("post_reset_1001", 48'hE66E10_000000, 6, 0);
`endif

    // Full repeat count, left to the model comparison
    apply_stimulus(1'b1, 4'b1000, 4'd15, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'b0111, 4'd3, 1'b0);
    repeat (15 * (PAT_W + 1) + 14 * GAP + 4) @(negedge clk);
    check_output("max_reps_end", 4'h0);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      pattern = PAT_W'($urandom);
      reps    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 15)) : CNT_W'($urandom_range(0, 3));
      abort   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    apply_stimulus(1'b0, 4'b0000, 4'd0, 1'b0);
    repeat (120) @(negedge clk);
    check_output("final_idle", 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
